// File: rtl/gyruss_gfx_fetch_arb.sv
`default_nettype none
// ============================================================================
// Module      : gyruss_gfx_fetch_arb
// Description : Shares one graphics-ROM read port between the BG character
//               fetcher and the sprite line fetcher, with anti-starvation
//               and a memory no-response timeout.
// Revision    : 1.0  initial release
// ============================================================================
module gyruss_gfx_fetch_arb #(
    parameter int BG_AW   = 13,
    parameter int SP_AW   = 14,
    parameter int MEM_AW  = 15,
    parameter int SP_MAXW = 4,
    parameter int TMO     = 63
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              BG_REQ,
    input  logic [BG_AW-1:0]  BG_ADDR,
    output logic              BG_ACK,
    input  logic              SP_REQ,
    input  logic [SP_AW-1:0]  SP_ADDR,
    output logic              SP_ACK,
    output logic [7:0]        RD_DATA,
    output logic              MEM_REQ,
    output logic [MEM_AW-1:0] MEM_ADDR,
    input  logic              MEM_RDY,
    input  logic [7:0]        MEM_DATA,
    output logic              TMO_ERR
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic [3:0] c_sp_maxw = 4'(SP_MAXW);
    localparam logic [7:0] c_tmo     = 8'(TMO);

    logic [1:0]        state_q, state_d;
    logic              sel_sp_q, sel_sp_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              tmo_err_q, tmo_err_d;

    logic              w_any_req;
    logic              w_grant_sp;
    logic              w_timeout;

    assign w_any_req  = BG_REQ | SP_REQ;
    assign w_grant_sp = SP_REQ & (~BG_REQ | (starve_cnt_q == c_sp_maxw));
    assign w_timeout  = (wait_cnt_q == c_tmo);

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_any_req) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_WAIT;
            ST_WAIT:  if (MEM_RDY || w_timeout) state_d = ST_ACK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_sp_d     = sel_sp_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_d   = mem_addr_q;
        rd_data_d    = rd_data_q;
        tmo_err_d    = tmo_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!SP_REQ || w_grant_sp) begin
                    starve_cnt_d = 4'd0;
                end else if (starve_cnt_q != c_sp_maxw) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
                if (w_any_req) begin
                    sel_sp_d   = w_grant_sp;
                    mem_addr_d = w_grant_sp ? {1'b1, (MEM_AW-1)'(SP_ADDR)}
                                            : {1'b0, (MEM_AW-1)'(BG_ADDR)};
                end
            end
            // Address is presented for one cycle before MEM_REQ rises.
            ST_GRANT: wait_cnt_d = 8'd1;
            ST_WAIT: begin
                if (MEM_RDY) begin
                    rd_data_d = MEM_DATA;
                end else if (w_timeout) begin
                    rd_data_d = 8'hFF;
                    tmo_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            sel_sp_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
            wait_cnt_q   <= 8'd0;
            mem_addr_q   <= '0;
            rd_data_q    <= 8'd0;
            tmo_err_q    <= 1'b0;
        end else begin
            sel_sp_q     <= sel_sp_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_addr_q   <= mem_addr_d;
            rd_data_q    <= rd_data_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    // Decoded from state so an async reset drops MEM_REQ immediately.
    always_comb begin
        MEM_REQ  = (state_q == ST_WAIT);
        BG_ACK   = (state_q == ST_ACK) && !sel_sp_q;
        SP_ACK   = (state_q == ST_ACK) &&  sel_sp_q;
        MEM_ADDR = mem_addr_q;
        RD_DATA  = rd_data_q;
        TMO_ERR  = tmo_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_gyruss_gfx_fetch_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_gyruss_gfx_fetch_arb
// Description : Self-checking bench for the BG/sprite graphics fetch arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gyruss_gfx_fetch_arb;

    localparam int SP_MAXW = 4;
    localparam int TMO     = 63;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        BG_REQ;
    logic [12:0] BG_ADDR;
    logic        BG_ACK;
    logic        SP_REQ;
    logic [13:0] SP_ADDR;
    logic        SP_ACK;
    logic [7:0]  RD_DATA;
    logic        MEM_REQ;
    logic [14:0] MEM_ADDR;
    logic        MEM_RDY;
    logic [7:0]  MEM_DATA;
    logic        TMO_ERR;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int mem_lat = 1;         // MEM_RDY in the mem_lat-th MEM_REQ cycle; 0 = never
    int mem_cnt = 0;
    logic [7:0] mem_val = 8'h00;
    bit stray_en = 1'b0;

    gyruss_gfx_fetch_arb #(
        .BG_AW(13), .SP_AW(14), .MEM_AW(15), .SP_MAXW(SP_MAXW), .TMO(TMO)
    ) dut (
        .MCLK(MCLK), .RESET(RESET),
        .BG_REQ(BG_REQ), .BG_ADDR(BG_ADDR), .BG_ACK(BG_ACK),
        .SP_REQ(SP_REQ), .SP_ADDR(SP_ADDR), .SP_ACK(SP_ACK),
        .RD_DATA(RD_DATA), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_RDY(MEM_RDY), .MEM_DATA(MEM_DATA), .TMO_ERR(TMO_ERR)
    );

    always #5 MCLK = ~MCLK;

    // One clock step plus the behavioural memory responder.
    task automatic tick();
        @(posedge MCLK);
        #1;
        cyc++;
        if (MEM_REQ) begin
            mem_cnt++;
            MEM_RDY  = (mem_lat != 0) && (mem_cnt == mem_lat);
            MEM_DATA = MEM_RDY ? mem_val : 8'($urandom);
        end else begin
            mem_cnt  = 0;
            MEM_RDY  = stray_en && ($urandom_range(0, 2) == 0);
            MEM_DATA = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        checks++; if (MEM_REQ !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", MEM_REQ); else passes++;
        checks++; if ({BG_ACK, SP_ACK} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {BG_ACK, SP_ACK}); else passes++;
        checks++; if (TMO_ERR !== 1'b0) $display("FAIL reset_tmo_err: got %b want 0", TMO_ERR); else passes++;
        checks++; if (RD_DATA !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", RD_DATA); else passes++;
        checks++; if (MEM_ADDR !== 15'h0000) $display("FAIL reset_mem_addr: got %h want 0000", MEM_ADDR); else passes++;
        RESET = 1'b0;
        tick(); tick();
        checks++; if (MEM_REQ !== 1'b0) $display("FAIL idle_mem_req: got %b want 0", MEM_REQ); else passes++;
    endtask

    task automatic test_bg_single();
        int start, bg_n, sp_n, ack_at;
        bit seen;
        logic [7:0] rd;
        BG_ADDR = 13'h0123; mem_lat = 2; mem_val = 8'hA5;
        BG_REQ = 1'b1; start = cyc;
        bg_n = 0; sp_n = 0; ack_at = -1; seen = 1'b0; rd = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (MEM_REQ && !seen) begin
                seen = 1'b1;
                checks++; if (MEM_ADDR !== 15'h0123) $display("FAIL bg_addr: got %h want 0123", MEM_ADDR); else passes++;
            end
            if (SP_ACK) sp_n++;
            if (BG_ACK) begin bg_n++; ack_at = cyc - start; rd = RD_DATA; BG_REQ = 1'b0; end
        end
        checks++; if (bg_n != 1) $display("FAIL bg_ack_count: got %0d want 1", bg_n); else passes++;
        checks++; if (ack_at != 4) $display("FAIL bg_latency: got %0d want 4", ack_at); else passes++;
        checks++; if (rd !== 8'hA5) $display("FAIL bg_data: got %h want a5", rd); else passes++;
        checks++; if (sp_n != 0) $display("FAIL bg_no_sp_ack: got %0d want 0", sp_n); else passes++;
    endtask

    task automatic test_sp_single();
        int start, bg_n, sp_n, ack_at, lat;
        bit seen;
        logic [7:0] rd, val;
        lat = $urandom_range(1, 5); val = 8'($urandom);
        SP_ADDR = 14'h2ABC; mem_lat = lat; mem_val = val;
        SP_REQ = 1'b1; start = cyc;
        bg_n = 0; sp_n = 0; ack_at = -1; seen = 1'b0; rd = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (MEM_REQ && !seen) begin
                seen = 1'b1;
                checks++; if (MEM_ADDR !== 15'h6ABC) $display("FAIL sp_addr: got %h want 6abc", MEM_ADDR); else passes++;
            end
            if (BG_ACK) bg_n++;
            if (SP_ACK) begin sp_n++; ack_at = cyc - start; rd = RD_DATA; SP_REQ = 1'b0; end
        end
        checks++; if (sp_n != 1) $display("FAIL sp_ack_count: got %0d want 1", sp_n); else passes++;
        checks++; if (ack_at != 2 + lat) $display("FAIL sp_latency: got %0d want %0d", ack_at, 2 + lat); else passes++;
        checks++; if (rd !== val) $display("FAIL sp_data: got %h want %h", rd, val); else passes++;
        checks++; if (bg_n != 0) $display("FAIL sp_no_bg_ack: got %0d want 0", bg_n); else passes++;
    endtask

    task automatic test_starvation();
        int starve, acks, next_ack, bad;
        bit exp_sp;
        BG_ADDR = 13'($urandom); SP_ADDR = 14'($urandom);
        mem_lat = 1; mem_val = 8'h77;
        BG_REQ = 1'b1; SP_REQ = 1'b1;
        starve = 0; acks = 0; bad = 0;
        next_ack = cyc + 3;
        for (int i = 0; i < 80 && acks < 10; i++) begin
            tick();
            if (BG_ACK && SP_ACK) bad++;
            if (BG_ACK || SP_ACK) begin
                exp_sp = (starve == SP_MAXW);
                starve = exp_sp ? 0 : ((starve + 1 > SP_MAXW) ? SP_MAXW : starve + 1);
                checks++; if (SP_ACK !== exp_sp) $display("FAIL starve_order[%0d]: got sp=%b want sp=%b", acks, SP_ACK, exp_sp); else passes++;
                checks++; if (cyc != next_ack) $display("FAIL starve_spacing[%0d]: got cyc %0d want %0d", acks, cyc, next_ack); else passes++;
                next_ack = cyc + mem_lat + 3;
                acks++;
            end
        end
        BG_REQ = 1'b0; SP_REQ = 1'b0;
        checks++; if (acks != 10) $display("FAIL starve_ack_total: got %0d want 10", acks); else passes++;
        checks++; if (bad != 0) $display("FAIL starve_both_acks: got %0d want 0", bad); else passes++;
        tick(); tick();
    endtask

    task automatic test_random_arb();
        int starve, start, lat, done_n, bad;
        bit bg_p, sp_p, exp_sp, seen, got;
        logic [14:0] exp_addr;
        logic [7:0]  val;
        starve = 0; bg_p = 1'b0; sp_p = 1'b0; done_n = 0; bad = 0;
        for (int n = 0; n < 40; n++) begin
            if (!bg_p && $urandom_range(0, 1) == 1) begin bg_p = 1'b1; BG_ADDR = 13'($urandom); end
            if (!sp_p && $urandom_range(0, 1) == 1) begin sp_p = 1'b1; SP_ADDR = 14'($urandom); end
            if (!bg_p && !sp_p) begin bg_p = 1'b1; BG_ADDR = 13'($urandom); end
            BG_REQ = bg_p; SP_REQ = sp_p;
            lat = $urandom_range(1, 6); val = 8'($urandom);
            mem_lat = lat; mem_val = val;
            exp_sp = sp_p && (!bg_p || starve == SP_MAXW);
            if (!sp_p || exp_sp) starve = 0;
            else if (starve < SP_MAXW) starve++;
            exp_addr = exp_sp ? {1'b1, SP_ADDR} : {2'b00, BG_ADDR};
            start = cyc; seen = 1'b0; got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                tick();
                if (MEM_REQ && !seen) begin
                    seen = 1'b1;
                    checks++; if (MEM_ADDR !== exp_addr) $display("FAIL rand_addr[%0d]: got %h want %h", n, MEM_ADDR, exp_addr); else passes++;
                end
                if (BG_ACK && SP_ACK) bad++;
                if (BG_ACK || SP_ACK) begin
                    got = 1'b1;
                    checks++; if (SP_ACK !== exp_sp || cyc - start != 2 + lat || RD_DATA !== val)
                        $display("FAIL rand_ack[%0d]: got sp=%b lat=%0d data=%h want sp=%b lat=%0d data=%h",
                                 n, SP_ACK, cyc - start, RD_DATA, exp_sp, 2 + lat, val);
                    else passes++;
                    if (exp_sp) sp_p = 1'b0; else bg_p = 1'b0;
                    BG_REQ = bg_p; SP_REQ = sp_p;
                end
            end
            if (got) done_n++;
            tick();
        end
        BG_REQ = 1'b0; SP_REQ = 1'b0;
        checks++; if (done_n != 40) $display("FAIL rand_completed: got %0d want 40", done_n); else passes++;
        checks++; if (bad != 0) $display("FAIL rand_both_acks: got %0d want 0", bad); else passes++;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int start, req_n, ack_at;
        logic [7:0] rd, val;
        checks++; if (TMO_ERR !== 1'b0) $display("FAIL tmo_err_before: got %b want 0", TMO_ERR); else passes++;
        mem_lat = 0; BG_ADDR = 13'($urandom); BG_REQ = 1'b1;
        start = cyc; req_n = 0; ack_at = -1; rd = 8'h00;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (MEM_REQ) req_n++;
            if (BG_ACK && ack_at < 0) begin ack_at = cyc - start; rd = RD_DATA; BG_REQ = 1'b0; end
        end
        checks++; if (ack_at != TMO + 2) $display("FAIL tmo_latency: got %0d want %0d", ack_at, TMO + 2); else passes++;
        checks++; if (req_n != TMO) $display("FAIL tmo_wait_cycles: got %0d want %0d", req_n, TMO); else passes++;
        checks++; if (rd !== 8'hFF) $display("FAIL tmo_data: got %h want ff", rd); else passes++;
        checks++; if (TMO_ERR !== 1'b1) $display("FAIL tmo_err_set: got %b want 1", TMO_ERR); else passes++;
        val = 8'($urandom); mem_lat = 3; mem_val = val;
        SP_ADDR = 14'($urandom); SP_REQ = 1'b1; rd = 8'h00; ack_at = -1; start = cyc;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (SP_ACK && ack_at < 0) begin ack_at = cyc - start; rd = RD_DATA; SP_REQ = 1'b0; end
        end
        checks++; if (rd !== val || ack_at != 5) $display("FAIL tmo_after_access: got data=%h lat=%0d want data=%h lat=5", rd, ack_at, val); else passes++;
        checks++; if (TMO_ERR !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", TMO_ERR); else passes++;
    endtask

    task automatic test_reset_mid_wait();
        int n, spurious, start, ack_at;
        logic [7:0] rd;
        mem_lat = 0; BG_ADDR = 13'h1F0F; BG_REQ = 1'b1; n = 0;
        do begin tick(); n++; end while (!MEM_REQ && n < 10);
        checks++; if (MEM_REQ !== 1'b1) $display("FAIL rst_reach_wait: got %b want 1", MEM_REQ); else passes++;
        tick(); tick();
        #2 RESET = 1'b1;
        #1;
        checks++; if (MEM_REQ !== 1'b0) $display("FAIL rst_async_mem_req: got %b want 0", MEM_REQ); else passes++;
        BG_REQ = 1'b0;
        @(posedge MCLK); #1; cyc++;
        RESET = 1'b0;
        MEM_RDY = 1'b1; MEM_DATA = 8'h3C;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge MCLK); #1; cyc++;
            MEM_RDY = 1'b0;
            if (BG_ACK || SP_ACK || MEM_REQ) spurious++;
        end
        checks++; if (spurious != 0) $display("FAIL rst_late_rdy_activity: got %0d want 0", spurious); else passes++;
        checks++; if (RD_DATA !== 8'h00 || TMO_ERR !== 1'b0) $display("FAIL rst_cleared: got data=%h err=%b want 00/0", RD_DATA, TMO_ERR); else passes++;
        mem_lat = 1; mem_val = 8'h5A; SP_ADDR = 14'h0F0F; SP_REQ = 1'b1;
        start = cyc; ack_at = -1; rd = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (SP_ACK && ack_at < 0) begin ack_at = cyc - start; rd = RD_DATA; SP_REQ = 1'b0; end
        end
        checks++; if (ack_at != 3 || rd !== 8'h5A) $display("FAIL rst_next_access: got lat=%0d data=%h want lat=3 data=5a", ack_at, rd); else passes++;
    endtask

    task automatic test_stray_and_drop();
        int spurious, bg_n, sp_n, start, ack_at;
        logic [7:0] rd, val;
        stray_en = 1'b1; spurious = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (BG_ACK || SP_ACK || MEM_REQ) spurious++;
        end
        checks++; if (spurious != 0) $display("FAIL stray_idle_activity: got %0d want 0", spurious); else passes++;
        val = 8'($urandom); mem_lat = 4; mem_val = val;
        BG_ADDR = 13'($urandom); BG_REQ = 1'b1;
        start = cyc; bg_n = 0; sp_n = 0; ack_at = -1; rd = 8'h00;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (MEM_REQ) BG_REQ = 1'b0;
            if (SP_ACK) sp_n++;
            if (BG_ACK) begin bg_n++; ack_at = cyc - start; rd = RD_DATA; end
        end
        stray_en = 1'b0;
        checks++; if (bg_n != 1 || sp_n != 0) $display("FAIL drop_ack_count: got bg=%0d sp=%0d want bg=1 sp=0", bg_n, sp_n); else passes++;
        checks++; if (ack_at != 6 || rd !== val) $display("FAIL drop_ack_data: got lat=%0d data=%h want lat=6 data=%h", ack_at, rd, val); else passes++;
    endtask

    initial begin
        RESET = 1'b1; BG_REQ = 1'b0; SP_REQ = 1'b0;
        BG_ADDR = '0; SP_ADDR = '0; MEM_RDY = 1'b0; MEM_DATA = 8'h00;
        repeat (2) @(posedge MCLK);
        #1;
        test_reset();
        test_bg_single();
        test_sp_single();
        test_starvation();
        test_random_arb();
        test_timeout();
        test_reset_mid_wait();
        test_stray_and_drop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
